// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the segment mux arbiter.
// Blanking in IDLE is enabled by defining SEG_MUX_ARB_BLANK_EN.
package seg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Active-low segments: all ones turns every segment off.
    localparam logic [6:0] SEG_BLANK     = 7'h7F;
    localparam int         DWELL_DEFAULT = 8;

endpackage

// File: rtl/mux2_1.sv
// Bitwise two-input mux; each output bit has its own select bit.
module mux2_1 #(
    parameter int W = 7
) (
    input  logic [W-1:0] i0,
    input  logic [W-1:0] i1,
    input  logic [W-1:0] sel,
    output logic [W-1:0] y
);

    assign y = (i0 & ~sel) | (i1 & sel);

endmodule

// File: rtl/seg_mux_arbiter.sv
// Round-robin arbiter sharing one segment mux between two requesters,
// with a minimum dwell time. Define SEG_MUX_ARB_BLANK_EN to blank in IDLE.
module seg_mux_arbiter
    import seg_arb_pkg::*;
#(
    parameter int DWELL = DWELL_DEFAULT,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req,
    input  logic [W-1:0] seg0,
    input  logic [W-1:0] seg1,
    output logic [1:0]   gnt,
    output logic         sel,
    output logic         busy,
    output logic [W-1:0] seg_out
);

    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

    arb_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_last;
    logic [1:0]    r_gnt;
    logic          r_sel;
    logic [W-1:0]  w_mux;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_gnt   <= '0;
            r_sel   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Requester 0 wins a tie unless it owned the display last.
                    if (req[0] && (!req[1] || r_last)) begin
                        r_state <= OWN0;
                        r_gnt   <= 2'b01;
                        r_sel   <= 1'b0;
                        r_last  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (req[1]) begin
                        r_state <= OWN1;
                        r_gnt   <= 2'b10;
                        r_sel   <= 1'b1;
                        r_last  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                OWN0: begin
                    if (req[1] && (!req[0] || r_cnt == CNT_MAX)) begin
                        r_state <= OWN1;
                        r_gnt   <= 2'b10;
                        r_sel   <= 1'b1;
                        r_last  <= 1'b1;
                        r_cnt   <= '0;
                    end else if (!req[0]) begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_cnt   <= '0;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                OWN1: begin
                    if (req[0] && (!req[1] || r_cnt == CNT_MAX)) begin
                        r_state <= OWN0;
                        r_gnt   <= 2'b01;
                        r_sel   <= 1'b0;
                        r_last  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (!req[1]) begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_cnt   <= '0;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    mux2_1 #(.W(W)) u_mux (
        .i0  (seg0),
        .i1  (seg1),
        .sel ({W{r_sel}}),
        .y   (w_mux)
    );

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = |r_gnt;

`ifdef SEG_MUX_ARB_BLANK_EN
    // OR-gating forces every active-low segment off while nobody owns the digit.
    assign seg_out = w_mux | {W{r_state == IDLE}};
`else
    assign seg_out = w_mux;
`endif

endmodule
